// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source enable, global enable, pending and priority vector.
// Optional edge-triggered sources are compiled in with the IRQ_EDGE_MODE_EN macro.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               select,
  input  logic [3:0]         we,
  input  logic               rd,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);

  // Only the first eight sources can be switched to edge mode.
  localparam int NE = (NUM_SRC < 8) ? NUM_SRC : 8;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic               gie;
  logic               wr;
  logic               wr_enable;
  logic               wr_pend;
  logic [3:0]         vec_idx;
  logic               vec_none;
  logic               unused_inputs;

  assign wr        = select && (we != 4'b0000);
  assign wr_enable = wr && (addr == 2'd1);
  assign wr_pend   = wr && (addr == 2'd2);
  assign active    = pending & enable;

  // rd is a strobe with no side effects; not every write-data bit maps to state.
  assign unused_inputs = ^{rd, we, wdata, wr_pend};

  // Stage boundary: source sampling, enables and the registered request.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      enable <= '0;
      gie    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      src_q <= src;
      irq   <= gie & (|active);
      if (wr_enable) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if ((i < 8) ? we[0] : we[1]) enable[i] <= wdata[i];
        end
        if (we[3]) gie <= wdata[31];
      end
    end
  end

`ifdef IRQ_EDGE_MODE_EN
  logic [NE-1:0] mode;
  logic [NE-1:0] mode_d;
  logic [NE-1:0] pend_edge;
  logic [NE-1:0] rise;
  logic [NE-1:0] clr;

  // A mode change discards stale latched state; a new rising edge still wins over any clear.
  always_comb begin
    mode_d = (wr_enable && we[2]) ? wdata[16 +: NE] : mode;
    rise   = src[NE-1:0] & ~src_q[NE-1:0];
    clr    = (mode_d ^ mode) | (wr_pend ? wdata[NE-1:0] : '0);
  end

  // Stage boundary: edge latches and mode bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= '0;
      pend_edge <= '0;
    end else begin
      mode      <= mode_d;
      pend_edge <= (pend_edge & ~clr) | rise;
    end
  end

  always_comb begin
    pending = src_q;
    for (int i = 0; i < NE; i++) begin
      if (mode[i]) pending[i] = pend_edge[i];
    end
  end
`else
  assign pending = src_q;
`endif

  // Lowest index wins, so scan downward and let the last hit stand.
  always_comb begin
    vec_idx  = 4'd0;
    vec_none = 1'b1;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx  = 4'(i);
        vec_none = 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[NUM_SRC-1:0] = active;
      2'd1: begin
        rdata[NUM_SRC-1:0] = enable;
        rdata[31]          = gie;
`ifdef IRQ_EDGE_MODE_EN
        rdata[16 +: NE]    = mode;
`endif
      end
      2'd2: rdata[NUM_SRC-1:0] = pending;
      default: begin
        rdata[31]  = vec_none;
        rdata[3:0] = vec_idx;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, edge-mode sequence, random vs. model.
module tb_irq_controller;
  localparam int N = 8;
`ifdef IRQ_EDGE_MODE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam logic [31:0] NONE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src;
  logic          select;
  logic [3:0]    we;
  logic          rd;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  int total = 0;
  int bad   = 0;

  irq_controller #(.NUM_SRC(N)) dut (
    .clk(clk), .reset(reset), .src(src), .select(select), .we(we), .rd(rd),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  s;
    logic [3:0]  w;
    logic [1:0]  a;
    logic [31:0] d;
    logic        e_irq;
    logic [31:0] e_st, e_en, e_pe, e_ve;
  } vec_t;
  vec_t tbl[$];

  // Behavioural model state, one entry per source.
  bit m_srcq[N];
  bit m_ep[N];
  bit m_en[N];
  bit m_mode[N];
  bit m_gie;
  bit m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] st, input logic [31:0] en,
                            input logic [31:0] pe, input logic [31:0] ve);
    addr = 2'd0; #1; check({tag, " STATUS"},  rdata, st);
    addr = 2'd1; #1; check({tag, " ENABLE"},  rdata, en);
    addr = 2'd2; #1; check({tag, " PENDING"}, rdata, pe);
    addr = 2'd3; #1; check({tag, " VECTOR"},  rdata, ve);
  endtask

  task automatic drive(input logic r, input logic [7:0] s, input logic [3:0] w,
                       input logic [1:0] a, input logic [31:0] d);
    reset = r; src = s; we = w; select = (w != 4'b0000); addr = a; wdata = d;
    tick();
    select = 1'b0; we = 4'b0000; reset = 1'b0;
  endtask

  task automatic add(input logic r, input logic [7:0] s, input logic [3:0] w, input logic [1:0] a,
                     input logic [31:0] d, input logic ei, input logic [31:0] st,
                     input logic [31:0] en, input logic [31:0] pe, input logic [31:0] ve);
    vec_t v;
    v.rst = r; v.s = s; v.w = w; v.a = a; v.d = d;
    v.e_irq = ei; v.e_st = st; v.e_en = en; v.e_pe = pe; v.e_ve = ve;
    tbl.push_back(v);
  endtask

  function automatic bit m_pend(input int i);
    return m_mode[i] ? m_ep[i] : m_srcq[i];
  endfunction

  task automatic model_step(input logic r, input logic [7:0] s, input logic sel,
                            input logic [3:0] w, input logic [1:0] a, input logic [31:0] d);
    bit en_n[N];
    bit mode_n[N];
    bit ep_n[N];
    bit gie_n;
    bit any;
    bit wr;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_srcq[i] = 0; m_ep[i] = 0; m_en[i] = 0; m_mode[i] = 0;
      end
      m_gie = 0; m_irq = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < N; i++) if (m_pend(i) && m_en[i]) any = 1;
    wr = sel && (w != 4'b0000);
    en_n = m_en; mode_n = m_mode; gie_n = m_gie;
    if (wr && a == 2'd1) begin
      for (int i = 0; i < N; i++) begin
        if ((i < 8) ? w[0] : w[1]) en_n[i] = d[i];
        if (EDGE && w[2] && i < 8) mode_n[i] = d[16 + i];
      end
      if (w[3]) gie_n = d[31];
    end
    for (int i = 0; i < N; i++) begin
      if (!mode_n[i])                        ep_n[i] = 0;
      else if (s[i] && !m_srcq[i])           ep_n[i] = 1;
      else if (!m_mode[i])                   ep_n[i] = 0;
      else if (wr && a == 2'd2 && d[i])      ep_n[i] = 0;
      else                                   ep_n[i] = m_ep[i];
    end
    m_irq = m_gie && any;
    m_en = en_n; m_mode = mode_n; m_ep = ep_n; m_gie = gie_n;
    for (int i = 0; i < N; i++) m_srcq[i] = s[i];
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] st, en, pe, ve;
    bit found;
    st = '0; en = '0; pe = '0; ve = NONE; found = 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend(i)) pe |= 32'(1) << i;
      if (m_pend(i) && m_en[i]) begin
        st |= 32'(1) << i;
        if (!found) begin
          ve = 32'(i);
          found = 1;
        end
      end
      if (m_en[i]) en |= 32'(1) << i;
      if (m_mode[i]) en |= 32'(1) << (16 + i);
    end
    if (m_gie) en |= NONE;
    check($sformatf("rand%0d irq", cyc), {31'b0, irq}, {31'b0, m_irq});
    check_regs($sformatf("rand%0d", cyc), st, en, pe, ve);
  endtask

  initial begin
    reset = 1'b1; src = '0; select = 1'b0; we = '0; rd = 1'b0; addr = '0; wdata = '0;

    //  rst src  we    a  wdata          irq STATUS ENABLE        PENDING VECTOR
    add(1, 8'h00, 4'h0, 0, 32'h0,          0, 32'h0, 32'h0,        32'h0, NONE);
    add(0, 8'h00, 4'hF, 1, 32'h8000_0005,  0, 32'h0, 32'h8000_0005, 32'h0, NONE);
    add(0, 8'h04, 4'h0, 0, 32'h0,          0, 32'h4, 32'h8000_0005, 32'h4, 32'h2);
    add(0, 8'h04, 4'h0, 0, 32'h0,          1, 32'h4, 32'h8000_0005, 32'h4, 32'h2);
    add(0, 8'h00, 4'h0, 0, 32'h0,          1, 32'h0, 32'h8000_0005, 32'h0, NONE);
    add(0, 8'h00, 4'h0, 0, 32'h0,          0, 32'h0, 32'h8000_0005, 32'h0, NONE);
    add(0, 8'h05, 4'h0, 0, 32'h0,          0, 32'h5, 32'h8000_0005, 32'h5, 32'h0);
    add(0, 8'h05, 4'hF, 1, 32'h8000_0004,  1, 32'h4, 32'h8000_0004, 32'h5, 32'h2);
    add(0, 8'h00, 4'hF, 1, 32'h0000_0002,  1, 32'h0, 32'h2,        32'h0, NONE);
    add(0, 8'h02, 4'h0, 0, 32'h0,          0, 32'h2, 32'h2,        32'h2, 32'h1);
    add(0, 8'h02, 4'h0, 0, 32'h0,          0, 32'h2, 32'h2,        32'h2, 32'h1);
    add(0, 8'h02, 4'hF, 1, 32'h8000_0002,  0, 32'h2, 32'h8000_0002, 32'h2, 32'h1);
    add(0, 8'h02, 4'h0, 0, 32'h0,          1, 32'h2, 32'h8000_0002, 32'h2, 32'h1);
    add(0, 8'h02, 4'h8, 1, 32'h0,          1, 32'h2, 32'h2,        32'h2, 32'h1);
    add(0, 8'h02, 4'h1, 1, 32'hFFFF_FF09,  0, 32'h0, 32'h9,        32'h2, NONE);
    add(0, 8'h02, 4'hF, 0, 32'hFFFF_FFFF,  0, 32'h0, 32'h9,        32'h2, NONE);
    add(0, 8'h0A, 4'hF, 2, 32'hFFFF_FFFF,  0, 32'h8, 32'h9,        32'hA, 32'h3);
    add(0, 8'h0A, 4'h2, 1, 32'h0000_FF00,  0, 32'h8, 32'h9,        32'hA, 32'h3);
    add(0, 8'h0A, 4'hF, 3, 32'hFFFF_FFFF,  0, 32'h8, 32'h9,        32'hA, 32'h3);
    add(1, 8'h08, 4'hF, 1, 32'hFFFF_FFFF,  0, 32'h0, 32'h0,        32'h0, NONE);
    add(0, 8'h08, 4'h0, 0, 32'h0,          0, 32'h0, 32'h0,        32'h8, NONE);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].s, tbl[k].w, tbl[k].a, tbl[k].d);
      check($sformatf("row%0d irq", k), {31'b0, irq}, {31'b0, tbl[k].e_irq});
      check_regs($sformatf("row%0d", k), tbl[k].e_st, tbl[k].e_en, tbl[k].e_pe, tbl[k].e_ve);
    end

`ifdef IRQ_EDGE_MODE_EN
    drive(1, 8'h00, 4'h0, 0, 32'h0);
    drive(0, 8'h00, 4'hF, 1, 32'h8001_0001);
    check_regs("edge cfg", 32'h0, 32'h8001_0001, 32'h0, NONE);
    drive(0, 8'h01, 4'h0, 0, 32'h0);
    check("edge latch irq", {31'b0, irq}, 32'h0);
    check_regs("edge latch", 32'h1, 32'h8001_0001, 32'h1, 32'h0);
    drive(0, 8'h00, 4'h0, 0, 32'h0);
    check("edge hold irq", {31'b0, irq}, 32'h1);
    drive(0, 8'h00, 4'h0, 0, 32'h0);
    check("edge hold2 irq", {31'b0, irq}, 32'h1);
    check_regs("edge hold2", 32'h1, 32'h8001_0001, 32'h1, 32'h0);
    drive(0, 8'h00, 4'hF, 2, 32'h1);
    check_regs("edge clear", 32'h0, 32'h8001_0001, 32'h0, NONE);
    drive(0, 8'h00, 4'h0, 0, 32'h0);
    check("edge clear irq", {31'b0, irq}, 32'h0);
    drive(0, 8'h01, 4'hF, 2, 32'h1);
    check_regs("edge setwins", 32'h1, 32'h8001_0001, 32'h1, 32'h0);
    drive(0, 8'h01, 4'h0, 0, 32'h0);
    check("edge setwins irq", {31'b0, irq}, 32'h1);
`endif

    drive(1, 8'h00, 4'h0, 0, 32'h0);
    model_step(1, 8'h00, 1'b0, 4'h0, 2'd0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      logic        r, sel;
      logic [7:0]  s;
      logic [3:0]  w;
      logic [1:0]  a;
      logic [31:0] d;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : src;
      sel = ($urandom_range(0, 2) == 0);
      w   = sel ? 4'($urandom) : 4'h0;
      a   = 2'($urandom);
      d   = $urandom;
      rd  = $urandom_range(0, 1) == 1;
      reset = r; src = s; select = sel; we = w; addr = a; wdata = d;
      tick();
      reset = 1'b0; select = 1'b0; we = 4'h0;
      model_step(r, s, sel, w, a, d);
      model_check(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
